// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing constants for the FIFO write-port arbiter and its
// round-robin picker.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int NUM_REQ_DFLT = 4;
  localparam int ID_W         = $clog2(NUM_REQ_DFLT);
  localparam int BEAT_W       = 8;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-write-side signals of the write-port arbiter.
// The arbiter takes the slave modport; producers/FIFO model take master.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  import fifo_arb_pkg::*;

  localparam int GID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        REQ_VALID;
  logic [NUM_REQ*DATA_W-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]        REQ_LAST;
  logic [NUM_REQ-1:0]        REQ_READY;
  logic                      FIFO_FULL;
  logic                      FIFO_WR_EN;
  logic [DATA_W-1:0]         FIFO_WR_DATA;
  logic                      GRANT_VALID;
  logic [GID_W-1:0]          GRANT_ID;
  logic [BEAT_W-1:0]         BEAT_COUNT;

  modport master (
    output REQ_VALID, REQ_DATA, REQ_LAST, FIFO_FULL,
    input  REQ_READY, FIFO_WR_EN, FIFO_WR_DATA, GRANT_VALID, GRANT_ID, BEAT_COUNT
  );

  modport slave (
    input  REQ_VALID, REQ_DATA, REQ_LAST, FIFO_FULL,
    output REQ_READY, FIFO_WR_EN, FIFO_WR_DATA, GRANT_VALID, GRANT_ID, BEAT_COUNT
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: returns the first set request
// at or after ptr, wrapping modulo N. Shared with the read-side scheduler.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    int           c;
    logic [W-1:0] cand;
    found = |req;
    idx   = '0;
    c     = 0;
    cand  = '0;
    // Scan from farthest to nearest so the nearest hit wins.
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      cand = W'(c);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port between NUM_REQ
// producers; bursts end on LAST or after MAX_BURST beats.
//   state | meaning
//   IDLE  | no owner; pick next requester from rr pointer (1 cycle)
//   BURST | owner's beats forwarded to FIFO, stalled by FIFO_FULL
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DFLT,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 8
) (
  input logic              WCLK,
  input logic              RST,
  fifo_wr_arbiter_if.slave bus
);

  localparam int GID_W = $clog2(NUM_REQ);

  arb_state_e        state_q, state_d;
  logic [GID_W-1:0]  owner_q, owner_d;
  logic [GID_W-1:0]  rr_q, rr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              pick_found;
  logic [GID_W-1:0]  pick_idx;
  logic              xfer;
  logic              burst_end;

  rr_pick #(.N(NUM_REQ), .W(GID_W)) u_rr_pick (
    .req   (bus.REQ_VALID),
    .ptr   (rr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge WCLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    rr_d             = rr_q;
    beat_d           = beat_q;
    xfer             = 1'b0;
    burst_end        = 1'b0;
    bus.REQ_READY    = '0;
    bus.FIFO_WR_EN   = 1'b0;
    bus.FIFO_WR_DATA = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          state_d = BURST;
        end
      end
      BURST: begin
        xfer                   = bus.REQ_VALID[owner_q] & ~bus.FIFO_FULL;
        bus.REQ_READY[owner_q] = ~bus.FIFO_FULL;
        bus.FIFO_WR_EN         = xfer;
        bus.FIFO_WR_DATA       = bus.REQ_DATA[owner_q*DATA_W +: DATA_W];
        if (xfer) begin
          // Truncation at MAX_BURST leaves the rest of the packet queued.
          burst_end = bus.REQ_LAST[owner_q] |
                      (({1'b0, beat_q} + 9'd1) == 9'(MAX_BURST));
          if (burst_end) begin
            state_d = IDLE;
            beat_d  = '0;
            rr_d    = (owner_q == GID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.GRANT_VALID = (state_q == BURST);
  assign bus.GRANT_ID    = owner_q;
  assign bus.BEAT_COUNT  = beat_q;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the async FIFO between NUM_REQ producers in the write-clock domain. It grants one requester at a time for a burst that ends on that requester's LAST beat or after MAX_BURST beats. It forwards data to the FIFO write port and back-pressures requesters from the FIFO full flag. It sits directly in front of the FIFO write side. The read side is untouched.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, data width; matches FIFO write data width
MAX_BURST, 8, maximum beats per grant (1..255)

Ports:
WCLK  in  1  write-domain clock; all logic on rising edge
RST  in  1  asynchronous, active-high reset
REQ_VALID  in  NUM_REQ  per-requester data valid
REQ_DATA  in  NUM_REQ*DATA_W  per-requester data; requester i occupies bits [i*DATA_W +: DATA_W]
REQ_LAST  in  NUM_REQ  marks final beat of a requester's packet
REQ_READY  out  NUM_REQ  per-requester accept; one-hot or zero
FIFO_FULL  in  1  FIFO full flag, write domain
FIFO_WR_EN  out  1  FIFO write enable
FIFO_WR_DATA  out  DATA_W  FIFO write data
GRANT_VALID  out  1  a burst owner is selected
GRANT_ID  out  $clog2(NUM_REQ)  current or last owner index
BEAT_COUNT  out  8  beats transferred in the current burst

Behaviour:
- Reset (async, RST=1):
  - state=IDLE; rr_ptr=0 (requester 0 has highest priority first).
  - GRANT_VALID=0, GRANT_ID=0, BEAT_COUNT=0.
  - REQ_READY=0 and FIFO_WR_EN=0 immediately.
  - FIFO_WR_DATA=0.
- FSM states: IDLE, BURST.
- IDLE:
  - If any REQ_VALID is set, choose the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register it as owner and go to BURST next cycle. Arbitration costs exactly 1 cycle.
  - No transfer happens in IDLE.
- BURST:
  - Transfer condition is combinational: xfer = REQ_VALID[owner] & ~FIFO_FULL.
  - REQ_READY[owner] = ~FIFO_FULL; all other READY bits are 0.
  - FIFO_WR_EN = xfer; FIFO_WR_DATA = REQ_DATA[owner] (muxed, zero-latency).
  - Each xfer increments BEAT_COUNT.
- Burst end: on an xfer with REQ_LAST[owner]=1, or with BEAT_COUNT+1==MAX_BURST.
  - Set rr_ptr = owner+1 (mod NUM_REQ).
  - Clear BEAT_COUNT, go to IDLE, GRANT_VALID=0.
  - GRANT_ID holds the last owner.
- MAX_BURST truncation does not consume LAST. The requester keeps its packet and re-arbitrates.
- FIFO_FULL during BURST: stall with no write and no count change; the grant is held indefinitely. The FIFO never sees WR_EN while FULL=1.
- Owner drops REQ_VALID mid-burst: the grant is held (bubble). Beats are not lost.
- Requests arriving during BURST wait; they are arbitrated at the next IDLE.
- Fairness: under full load each requester is granted in turn 0,1,2,3,0,...
- rr_ptr wraps from NUM_REQ-1 to 0.
- RST mid-burst: everything is cleared at once and any in-flight beat is dropped. Requesters must restart packets.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum (IDLE, BURST)
  - localparam ID_W = $clog2(NUM_REQ)
  - beat counter width constant (8)
- Sub-module rr_pick: combinational round-robin priority encoder. Inputs are a request vector and rr_ptr; outputs are a found flag and an index. It is reused later for the read-side scheduler.
- The top holds the FSM, counter and data mux.

Test Plan:
1. Single requester: R0 sends 3 beats 0x11,0x22,0x33 with LAST on 0x33, FIFO not full -> GRANT_VALID a cycle after VALID; 3 consecutive FIFO_WR_EN pulses with data 0x11,0x22,0x33; back to IDLE; rr_ptr=1.
2. Round-robin: R0..R3 all request single-beat packets 0xA0..0xA3 continuously for 8 packets -> write order 0xA0,0xA1,0xA2,0xA3,0xA0... with GRANT_ID 0,1,2,3,0...; one idle arbitration cycle between bursts.
3. MAX_BURST=8, R1 sends a 12-beat packet with R2 also requesting -> R1 writes 8 beats, R2 granted next, then R1 resumes the remaining 4; no beat lost or duplicated (scoreboard).
4. FIFO_FULL asserted for 5 cycles mid-burst after beat 2 -> FIFO_WR_EN=0 and REQ_READY=0 for those 5 cycles; BEAT_COUNT holds at 2; resume with beat 3 on the cycle FULL clears.
5. Owner drops VALID for 3 cycles mid-burst while R3 requests -> grant held on owner; R3 not granted until owner's LAST.
6. RST pulsed during BURST at beat 4 -> same-cycle REQ_READY=0 and FIFO_WR_EN=0; after release GRANT_ID=0 and BEAT_COUNT=0; the next arbitration starts from R0.
